// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } add_state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// Combinational 4-bit ripple adder built from chained full-adder cells with carry-in.
module nibble_adder_cin
  import adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder: one nibble per cycle through a shared 4-bit slice, carry held in a register.
// Operand/result exchange uses valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         busy
);

  localparam int unsigned W  = NIBBLE_W * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  add_state_t     state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   sum_sh_q, sum_sh_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [NIBBLE_W-1:0]   slice_s;
  logic                  slice_c;
  logic [W+NIBBLE_W-1:0] sum_cat;

  nibble_adder_cin u_slice (
    .sum  (slice_s),
    .cout (slice_c),
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q)
  );

  // New nibble enters at the MSB end; after NIBBLES shifts nibble 0 sits at the bottom.
  assign sum_cat = {slice_s, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        sum_sh_d = sum_cat[W+NIBBLE_W-1:NIBBLE_W];
        carry_d  = slice_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = slice_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_sh_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a 4-nibble instance and a 1-nibble instance share clock/reset.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, cout1, busy1;
  logic [3:0]  a1, b1, sum1;

  int errors;
  int checks;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation on the 4-nibble instance with out_ready held high.
  // lat = cycles from the handshake cycle to the first cycle with out_valid (-1 on timeout).
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int lat,
                        output logic [15:0] s, output logic c);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    s = 'x;
    c = 1'bx;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        s = sum;
        c = cout;
        break;
      end
    end
    if (lat == 0) lat = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 0000 0",
               in_ready, out_valid, busy, sum, cout);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1, sum1, cout1} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: got rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 0 0",
               in_ready1, out_valid1, busy1, sum1, cout1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] s;
    logic c;
    run_op(16'h1234, 16'h1111, lat, s, c);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 5", lat);
    end
    checks++;
    if ({c, s} !== 17'h02345) begin
      errors++;
      $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=2345", c, s);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    logic [15:0] s;
    logic c;
    run_op(16'hFFFF, 16'h0001, lat, s, c);
    checks++;
    if ({c, s} !== 17'h10000) begin
      errors++;
      $display("FAIL carry_ripple: got cout=%b sum=%h, want cout=1 sum=0000", c, s);
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    int n;
    @(negedge clk);
    a = 16'hA5C3;
    b = 16'h7E19;
    exp = {1'b0, a} + {1'b0, b};
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_done_timeout: out_valid=%b after %0d cycles, want 1", out_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, cout, sum} !== {1'b1, 1'b0, 1'b1, exp}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b busy=%b cout=%b sum=%h, want 1 0 1 %b %h",
                 i, out_valid, in_ready, busy, cout, sum, exp[16], exp[15:0]);
      end
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, cout, sum} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL bp_release: got vld=%b cout=%b sum=%h, want 1 %b %h",
               out_valid, cout, sum, exp[16], exp[15:0]);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_after: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [15:0] s;
    logic c;
    @(negedge clk);
    a = 16'h9876;
    b = 16'h5555;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    // Cycles 1..3 after the handshake carry cnt 0..2.
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrun_state: got busy=%b vld=%b, want busy=1 vld=0", busy, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b, want 1 0 0 0000 0",
               in_ready, out_valid, busy, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h8000, 16'h8000, lat, s, c);
    checks++;
    if ({c, s} !== 17'h10000 || lat !== 5) begin
      errors++;
      $display("FAIL after_reset_op: got cout=%b sum=%h lat=%0d, want cout=1 sum=0000 lat=5",
               c, s, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] exp;
    logic accepted;
    int got, sent, cyc, prev_acc;
    a = 16'($urandom);
    b = 16'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    got = 0;
    sent = 0;
    cyc = 0;
    prev_acc = -1;
    while (got < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: got cout=%b sum=%h with no pending operand", cout, sum);
        end else begin
          exp = q.pop_front();
          if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got cout=%b sum=%h, want cout=%b sum=%h",
                     got, cout, sum, exp[16], exp[15:0]);
          end
        end
        got++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        q.push_back({1'b0, a} + {1'b0, b});
        if (prev_acc >= 0) begin
          checks++;
          if (cyc - prev_acc != 6) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 6", sent, cyc - prev_acc);
          end
        end
        prev_acc = cyc;
        sent++;
      end
      @(posedge clk);
      #1;
      if (accepted) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (sent == 100) in_valid = 1'b0;
      end
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want 100", got);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_nibble();
    int lat;
    @(negedge clk);
    a1 = 4'hF;
    b1 = 4'hF;
    in_valid1 = 1'b1;
    out_ready1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL n1_ready: got %b, want 1", in_ready1);
    end
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL n1_latency: got %0d cycles, want 2", lat);
    end
    checks++;
    if ({cout1, sum1} !== 5'h1E) begin
      errors++;
      $display("FAIL n1_sum: got cout=%b sum=%h, want cout=1 sum=e", cout1, sum1);
    end
    @(negedge clk);
    checks++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      errors++;
      $display("FAIL n1_after: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    a1 = '0;
    b1 = '0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_single_nibble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
